// File: rtl/pic_sequencer.sv
// pic_sequencer: rotating-priority interrupt resolver with INTA sequencing, ISR, EOI and poll
// Ports: clock, reset_n (sync, active-low); irq_request/irq_mask from the IRR logic;
//   vector_base, mode_8086, auto_eoi, auto_rotate configuration; eoi_* EOI command strobe;
//   poll_request/read_strobe CPU poll; interrupt_acknowledge_n INTA in; interrupt_to_cpu INT out;
//   data_out/data_out_valid bus byte; in_service ISR; clear_interrupt_request pulse to IRR;
//   priority_base current highest-priority level; busy when not READY.
module pic_sequencer #(
   parameter int NUM_IRQ = 8,
   parameter int VECTOR_W = 8,
   localparam int ID_W = $clog2(NUM_IRQ)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [NUM_IRQ-1:0]  irq_request,
   input  logic [NUM_IRQ-1:0]  irq_mask,
   input  logic [VECTOR_W-1:0] vector_base,
   input  logic                mode_8086,
   input  logic                auto_eoi,
   input  logic                auto_rotate,
   input  logic                eoi_valid,
   input  logic                eoi_specific,
   input  logic                eoi_rotate,
   input  logic [ID_W-1:0]     eoi_level,
   input  logic                poll_request,
   input  logic                read_strobe,
   input  logic                interrupt_acknowledge_n,
   output logic                interrupt_to_cpu,
   output logic [VECTOR_W-1:0] data_out,
   output logic                data_out_valid,
   output logic [NUM_IRQ-1:0]  in_service,
   output logic [NUM_IRQ-1:0]  clear_interrupt_request,
   output logic [ID_W-1:0]     priority_base,
   output logic                busy
);
   typedef enum logic [2:0] {READY, ACK1, ACK2, ACK3, POLL} state_t;
   state_t state, state_next;
   logic inta_prev, fall, rise, eos, take, poll_rd;
   logic [ID_W-1:0] id, lvl, cand_id, isr_id, eoi_id, base_next;
   logic cand_valid, isr_valid, eoi_clr, bus_dv, dv_next;
   logic [NUM_IRQ-1:0] set_mask, clr_mask, isr_next;
   logic [VECTOR_W-1:0] vec, poll_byte, bus_val, dout_next;
   assign fall = inta_prev & ~interrupt_acknowledge_n;
   assign rise = ~inta_prev & interrupt_acknowledge_n;
   assign busy = state != READY;
   // Scan from priority_base upward; the first set ISR bit blocks every level after it,
   // including itself, which gives fully nested behaviour.
   always_comb begin
      lvl = '0;
      cand_valid = 1'b0;
      cand_id = '1;
      isr_valid = 1'b0;
      isr_id = '0;
      for (int k = 0; k < NUM_IRQ; k++) begin
         lvl = priority_base + ID_W'(k);
         if (!isr_valid && in_service[lvl]) begin
            isr_valid = 1'b1;
            isr_id = lvl;
         end
         if (!isr_valid && !cand_valid && irq_request[lvl] && !irq_mask[lvl]) begin
            cand_valid = 1'b1;
            cand_id = lvl;
         end
      end
   end
   always_comb begin
      state_next = state;
      case (state)
         READY: state_next = fall ? ACK1 : poll_request ? POLL : READY;
         ACK1:  state_next = rise ? ACK2 : ACK1;
         ACK2:  state_next = rise ? (mode_8086 ? READY : ACK3) : ACK2;
         ACK3:  state_next = rise ? READY : ACK3;
         POLL:  state_next = read_strobe ? READY : POLL;
         default: state_next = READY;
      endcase
   end
   always_comb begin
      eos = rise & (state == ACK3 | (state == ACK2 & mode_8086));
      take = state == READY & fall;
      poll_rd = state == POLL & read_strobe;
      set_mask = ((take | poll_rd) & cand_valid) ? NUM_IRQ'(1) << cand_id : '0;
      eoi_clr = eoi_valid & (eoi_specific | isr_valid);
      eoi_id = eoi_specific ? eoi_level : isr_id;
      clr_mask = (eoi_clr ? NUM_IRQ'(1) << eoi_id : '0) | ((eos & auto_eoi) ? NUM_IRQ'(1) << id : '0);
      isr_next = (in_service & ~clr_mask) | set_mask;
      base_next = (eoi_clr & eoi_rotate) ? eoi_id + ID_W'(1) :
                  (eos & auto_eoi & auto_rotate) ? id + ID_W'(1) : priority_base;
      vec = vector_base;
      vec[ID_W-1:0] = id;
      poll_byte = '0;
      poll_byte[VECTOR_W-1] = cand_valid;
      poll_byte[ID_W-1:0] = cand_valid ? cand_id : '0;
      // Bus contents follow the state the sequence is in while INTA is held low.
      bus_dv = ~interrupt_acknowledge_n & ((state_next == ACK1 & ~mode_8086) | state_next == ACK2 | state_next == ACK3);
      bus_val = state_next == ACK1 ? VECTOR_W'(8'hCD) : state_next == ACK2 ? vec : '0;
      dv_next = poll_rd | bus_dv;
      dout_next = poll_rd ? poll_byte : bus_dv ? bus_val : '0;
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= READY;
         inta_prev <= 1'b1;
         id <= '0;
         in_service <= '0;
         priority_base <= '0;
         interrupt_to_cpu <= 1'b0;
         data_out <= '0;
         data_out_valid <= 1'b0;
         clear_interrupt_request <= '0;
      end else begin
         state <= state_next;
         inta_prev <= interrupt_acknowledge_n;
         if (take) id <= cand_id;
         in_service <= isr_next;
         priority_base <= base_next;
         interrupt_to_cpu <= state == READY & cand_valid;
         data_out <= dout_next;
         data_out_valid <= dv_next;
         clear_interrupt_request <= set_mask;
      end
   end
endmodule

// File: doc/pic_sequencer.md
# pic_sequencer

Parametrised, fully synchronous successor of the PIC control logic. It resolves priority across NUM_IRQ request lines with rotating priority, drives INT to the CPU, and sequences 8086 two-pulse or MCS-80 three-pulse INTA cycles. It also owns the in-service register, EOI handling (non-specific, specific, rotate, auto-EOI) and poll mode. It sits between the interrupt-request/mask logic and the data-bus buffer.

## Interface
- NUM_IRQ, 8, number of request levels; power of 2, 2..32
- ID_W, $clog2(NUM_IRQ), level index width (derived, not overridden)
- VECTOR_W, 8, width of vector base and data_out
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- irq_request  in  NUM_IRQ  pending requests (IRR), already synchronised
- irq_mask  in  NUM_IRQ  1 = level masked
- vector_base  in  VECTOR_W  vector; low ID_W bits replaced by level id
- mode_8086  in  1  1 = two-pulse INTA, 0 = three-pulse MCS-80
- auto_eoi  in  1  clear ISR bit at end of INTA sequence
- auto_rotate  in  1  with auto_eoi: rotate priority at end of sequence
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = clear eoi_level, 0 = clear highest-priority ISR bit
- eoi_rotate  in  1  cleared level becomes lowest priority
- eoi_level  in  ID_W  level for specific EOI
- poll_request  in  1  one-cycle poll command strobe
- read_strobe  in  1  one-cycle CPU read strobe
- interrupt_acknowledge_n  in  1  INTA, active-low, synchronised
- interrupt_to_cpu  out  1  INT, registered
- data_out  out  VECTOR_W  byte for the data bus
- data_out_valid  out  1  data_out must drive the bus
- in_service  out  NUM_IRQ  ISR
- clear_interrupt_request  out  NUM_IRQ  one-cycle one-hot pulse to IRR logic
- priority_base  out  ID_W  highest-priority level
- busy  out  1  state != READY

## Operation
- Priority: the scan starts at priority_base and runs upward modulo NUM_IRQ. The scan order is the priority order. candidate = first level with request & ~mask whose priority is strictly higher than the highest-priority set ISR bit (fully nested). cand_valid flags that a candidate exists.
- States: READY, ACK1, ACK2, ACK3, POLL. An INTA edge is detected against a registered previous INTA (reset value 1).
- READY, falling INTA edge → ACK1.
  - Latch candidate id (freeze), set its ISR bit, pulse its clear_interrupt_request bit.
  - If cand_valid=0 (spurious): id = NUM_IRQ-1, no ISR set, no clear pulse.
- ACK1, rising edge → ACK2.
- ACK2, rising edge → ACK3 if mode_8086=0, else end of sequence.
- ACK3, rising edge → end of sequence.
- End of sequence: return to READY. If auto_eoi, clear the latched ISR bit. If auto_eoi & auto_rotate, priority_base = id+1 mod NUM_IRQ.
- Bus data while INTA is low, by mode and state:
  - 8086, ACK1: nothing.
  - 8086, ACK2: {vector_base[VECTOR_W-1:ID_W], id}.
  - MCS-80, ACK1: 8'hCD (zero-extended).
  - MCS-80, ACK2: vector.
  - MCS-80, ACK3: 0.
- poll_request in READY → POLL. In POLL:
  - interrupt_to_cpu = 0; INTA edges ignored.
  - On read_strobe: data_out = {cand_valid, zeros, id}, data_out_valid for 1 cycle. If cand_valid, set ISR bit and pulse clear. Return to READY.
- poll_request outside READY is ignored.
- EOI, accepted in any state:
  - Non-specific clears the highest-priority set ISR bit; no-op if ISR is empty.
  - Specific clears eoi_level.
  - eoi_rotate sets priority_base = cleared level + 1 mod NUM_IRQ. With a non-specific EOI and an empty ISR, no rotation.
- Same-cycle EOI clear and ISR set: apply the clear first, then the set. A set always wins on the same bit.
- interrupt_to_cpu = registered (state==READY & cand_valid).

## Timing
- Reset (reset_n low at an edge): state READY, in_service 0, priority_base 0, interrupt_to_cpu 0, data_out 0, data_out_valid 0, clear_interrupt_request 0, busy 0, prev INTA 1. Reset mid-sequence aborts with no EOI or rotate side effects.
- interrupt_to_cpu rises 1 cycle after a candidate appears. It falls the cycle after the INTA falling edge is sampled.
- ISR set and clear pulse are registered 1 cycle after the edge is sampled. The clear pulse is exactly 1 cycle wide.
- data_out/data_out_valid update 1 cycle after the falling edge of the data-bearing pulse. They drop 1 cycle after its rising edge.
- EOI takes effect on in_service/priority_base 1 cycle after eoi_valid.

## Test plan
- NUM_IRQ=8, 8086, vector_base=8'h40, request IR3 → interrupt_to_cpu=1 next cycle; two INTA pulses → second pulse data_out=8'h43, in_service=8'h08, clear_interrupt_request pulses 8'h08 once.
- MCS-80, IR5, vector_base=8'h20 → pulse1 8'hCD, pulse2 8'h25, pulse3 8'h00. Non-specific EOI → in_service=0.
- auto_eoi=1, auto_rotate=1, IR2 serviced → in_service=0, priority_base=3. Then requests IR1 and IR4 → IR4 serviced first.
- IR6 in service, IR2 request (base 0) → INT asserted, IR2 nests. Specific EOI level 2 with eoi_rotate → priority_base=3, in_service=8'h40.
- Poll with IR7 pending → data_out=8'h87 on read_strobe, ISR bit 7 set. Poll with nothing pending → 8'h00. INTA pulse during POLL → no state change.
- Request withdrawn before INTA → spurious: data_out vector id 7, in_service unchanged. Reset asserted in ACK2 → all outputs at reset values next cycle.
